host_bus_master: RTL and testbench
==================================

# host_bus_master

Synchronous bus-master engine that turns single-byte command/data requests into S1D13700-style 8080 bus cycles (cs_x, a0, wr_x, rd_x, 8-bit data). It sits between a controller-side request interface and the LCD controller's parallel port. It replaces the testbench host tasks CMD_WR/DAT_WR with a synthesizable, parameter-timed equivalent.

## Interface
- SETUP_CYC, default 1: cycles cs_x/a0/data are valid before the strobe falls (1..15).
- PULSE_CYC, default 2: strobe low width in cycles (1..15).
- HOLD_CYC, default 1: cycles cs_x/a0/data are held after the strobe rises (1..15).
- RECOV_CYC, default 2: cs_x-high recovery cycles before the next access (1..15).
- clk  in  1  single system clock; all logic on its rising edge.
- rst  in  1  reset; synchronous, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  engine idle and able to accept.
- req_a0  in  1  1 = command, 0 = data (S1D13700 encoding).
- req_rd  in  1  1 = read cycle, 0 = write cycle.
- req_dat  in  8  write byte.
- done  out  1  one-cycle pulse at the end of every access.
- rd_data  out  8  captured read byte.
- rd_valid  out  1  one-cycle pulse with rd_data.
- cs_x, wr_x, rd_x  out  1  active-low bus strobes.
- a0  out  1  bus address line.
- dat_o  out  8  bus write data.
- dat_oe  out  1  bus data output enable.
- dat_i  in  8  bus read data.

## Operation
- States: IDLE, SETUP, STROBE, HOLD, RECOV.
- IDLE: req_ready=1. On req_valid&req_ready, latch a0/rd/dat, go to SETUP.
- SETUP (SETUP_CYC cycles): cs_x=0, a0=latched. For a write, dat_oe=1 and dat_o=latched byte.
- STROBE (PULSE_CYC cycles): for a write, wr_x=0; for a read, rd_x=0 and dat_oe=0. On the last STROBE cycle of a read, register dat_i into rd_data.
- HOLD (HOLD_CYC cycles): strobes high; cs_x, a0 and dat_o unchanged.
- RECOV (RECOV_CYC cycles): cs_x=1, dat_oe=0. done=1 on the final RECOV cycle, plus rd_valid=1 for a read. Then go to IDLE.
- A parameter value of 0 is treated as 1.
- Only one access is in flight at a time. req_valid is ignored while req_ready=0.
- wr_x and rd_x are never low simultaneously.

## Timing
- Reset values: cs_x=1, wr_x=1, rd_x=1, a0=0, dat_o=0x00, dat_oe=0, req_ready=1, done=0, rd_data=0x00, rd_valid=0, state IDLE.
- Request accepted at edge N: cs_x falls at N+1.
- Strobe falls at N+1+SETUP_CYC and rises at N+1+SETUP_CYC+PULSE_CYC.
- cs_x rises at N+1+SETUP_CYC+PULSE_CYC+HOLD_CYC.
- req_ready returns at N+1+SETUP_CYC+PULSE_CYC+HOLD_CYC+RECOV_CYC. With defaults, a 6-cycle access.
- A back-to-back request may be accepted on the first cycle req_ready is high.
- All outputs are registered, with no combinational path from inputs to outputs.
- rst mid-access: all outputs return to reset values at the next edge; the access is aborted with no done and no rd_valid.

## Configuration
- HOST_BUS_RD_EN defined: read cycles are supported as described above.
- Not defined:
  - req_rd is ignored; every request is a write.
  - rd_x is constant 1, rd_data is constant 0x00, rd_valid is constant 0.
  - dat_i is unused.

## Structure
- Package host_bus_pkg holds:
  - the state enum;
  - A0_CMD=1 and A0_DAT=0;
  - the counter width constant (4).
- One sub-module, host_bus_timer: a loadable down-counter with a load value and a terminal-count flag, reused for every phase.

## Test plan
- Reset then idle: check every reset value, and that req_ready stays 1 with no bus activity.
- Command write 0x40 (a0=1), defaults:
  - cs_x low for 4 cycles, wr_x low for exactly 2 cycles, dat_o=0x40 throughout cs_x low;
  - done pulses once and req_ready returns 6 cycles after acceptance.
- Sequence CMD 0x40, data 01 02 03 04 48 05 06, CMD 0x42, data 22 33 44, CMD 0x40 (req_valid held high):
  - 13 bus cycles in order with correct a0;
  - 13 done pulses;
  - cs_x high ≥2 cycles between accesses.
- Parameters SETUP=3, PULSE=4, HOLD=2, RECOV=1: edge timings match the Timing formulas; total access 10 cycles.
- Read with HOST_BUS_RD_EN, dat_i=0xA5 during the strobe: rd_x low 2 cycles, wr_x stays 1, dat_oe=0, rd_data=0xA5 with a rd_valid pulse. Without the macro, the same stimulus produces a write cycle and no rd_valid.
- rst asserted during STROBE: bus idles at the next edge, no done; the next request then completes normally.

Source files
------------

// File: rtl/host_bus_pkg.sv
// host_bus_pkg: shared types and constants for the host_bus_master 8080-style
// bus engine (state encoding, a0 encoding, phase counter width).
package host_bus_pkg;

   // Phase counter width; every phase length fits in 1..15 cycles.
   localparam int CNT_W = 4;

   // S1D13700 a0 encoding.
   localparam logic A0_CMD = 1'b1;
   localparam logic A0_DAT = 1'b0;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_SETUP  = 3'd1,
      ST_STROBE = 3'd2,
      ST_HOLD   = 3'd3,
      ST_RECOV  = 3'd4
   } state_e;

   // Counter load value for a phase of 'cyc' cycles. The timer counts
   // load..0, so a phase of N cycles loads N-1; a length of 0 acts as 1.
   function automatic logic [CNT_W-1:0] phase_load(input int unsigned cyc);
      if (cyc == 0) return '0;
      return CNT_W'(cyc - 1);
   endfunction

endpackage

// File: rtl/host_bus_timer.sv
// host_bus_timer: loadable down-counter with a terminal-count flag. The engine
// reloads it on every phase entry and advances when tc is seen.
module host_bus_timer
   import host_bus_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   output logic             tc
);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   // Next count: load wins, otherwise count down and park at zero.
   always_comb begin
      cnt_d = cnt_q;
      if (load)
         cnt_d = load_val;
      else if (cnt_q != '0)
         cnt_d = cnt_q - 1'b1;
   end

   // Counter register.
   always_ff @(posedge clk) begin
      if (rst)
         cnt_q <= '0;
      else
         cnt_q <= cnt_d;
   end

   assign tc = (cnt_q == '0);

endmodule

// File: rtl/host_bus_master.sv
// host_bus_master: turns single-byte command/data requests into S1D13700-style
// 8080 bus cycles (cs_x, a0, wr_x, rd_x, 8-bit data) with parameterised
// setup / strobe / hold / recovery timing.
// Optional feature macro: HOST_BUS_RD_EN enables read cycles; without it every
// request is a write and the read-side outputs are tied off.
module host_bus_master
   import host_bus_pkg::*;
#(
   parameter int unsigned SETUP_CYC = 1,
   parameter int unsigned PULSE_CYC = 2,
   parameter int unsigned HOLD_CYC  = 1,
   parameter int unsigned RECOV_CYC = 2
)(
   input  logic       clk,
   input  logic       rst,
   input  logic       req_valid,
   output logic       req_ready,
   input  logic       req_a0,
   input  logic       req_rd,
   input  logic [7:0] req_dat,
   output logic       done,
   output logic [7:0] rd_data,
   output logic       rd_valid,
   output logic       cs_x,
   output logic       wr_x,
   output logic       rd_x,
   output logic       a0,
   output logic [7:0] dat_o,
   output logic       dat_oe,
   input  logic [7:0] dat_i
);

   localparam logic [CNT_W-1:0] SETUP_LD = phase_load(SETUP_CYC);
   localparam logic [CNT_W-1:0] PULSE_LD = phase_load(PULSE_CYC);
   localparam logic [CNT_W-1:0] HOLD_LD  = phase_load(HOLD_CYC);
   localparam logic [CNT_W-1:0] RECOV_LD = phase_load(RECOV_CYC);

   state_e           state_q, state_d;
   logic             a0_lat_q, a0_lat_d;
   logic             rd_lat_q, rd_lat_d;
   logic [7:0]       dat_lat_q, dat_lat_d;

   logic             req_ready_q, req_ready_d;
   logic             cs_x_q, cs_x_d;
   logic             wr_x_q, wr_x_d;
   logic             a0_q, a0_d;
   logic [7:0]       dat_o_q, dat_o_d;
   logic             dat_oe_q, dat_oe_d;
   logic             done_q, done_d;

   logic             accept;
   logic             req_rd_eff;
   logic             tmr_load;
   logic [CNT_W-1:0] tmr_val;
   logic             tmr_tc;
   logic             in_bus;
   logic             strobe;
   logic             last_recov;

   // req_ready is a flop, so acceptance depends only on registered state.
   assign accept = req_valid & req_ready_q;

`ifdef HOST_BUS_RD_EN
   assign req_rd_eff = req_rd;
`else
   assign req_rd_eff = 1'b0;
   logic unused_rd_inputs;
   assign unused_rd_inputs = ^{req_rd, dat_i};
`endif

   host_bus_timer u_timer (
      .clk      (clk),
      .rst      (rst),
      .load     (tmr_load),
      .load_val (tmr_val),
      .tc       (tmr_tc)
   );

   // Phase sequencer: each phase reloads the timer with its own length.
   always_comb begin
      state_d   = state_q;
      tmr_load  = 1'b0;
      tmr_val   = '0;
      a0_lat_d  = a0_lat_q;
      rd_lat_d  = rd_lat_q;
      dat_lat_d = dat_lat_q;
      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               state_d   = ST_SETUP;
               tmr_load  = 1'b1;
               tmr_val   = SETUP_LD;
               a0_lat_d  = req_a0;
               rd_lat_d  = req_rd_eff;
               dat_lat_d = req_dat;
            end
         end
         ST_SETUP: begin
            if (tmr_tc) begin
               state_d  = ST_STROBE;
               tmr_load = 1'b1;
               tmr_val  = PULSE_LD;
            end
         end
         ST_STROBE: begin
            if (tmr_tc) begin
               state_d  = ST_HOLD;
               tmr_load = 1'b1;
               tmr_val  = HOLD_LD;
            end
         end
         ST_HOLD: begin
            if (tmr_tc) begin
               state_d  = ST_RECOV;
               tmr_load = 1'b1;
               tmr_val  = RECOV_LD;
            end
         end
         ST_RECOV: begin
            if (tmr_tc)
               state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Bus outputs decoded from the current phase; registered one cycle later,
   // which is why cs_x falls the cycle after acceptance.
   always_comb begin
      in_bus      = (state_q == ST_SETUP) || (state_q == ST_STROBE) || (state_q == ST_HOLD);
      strobe      = (state_q == ST_STROBE);
      last_recov  = (state_q == ST_RECOV) && tmr_tc;
      req_ready_d = (state_q == ST_IDLE) && !accept;
      cs_x_d      = !in_bus;
      a0_d        = in_bus ? a0_lat_q  : a0_q;
      dat_o_d     = in_bus ? dat_lat_q : dat_o_q;
      dat_oe_d    = in_bus && !rd_lat_q;
      wr_x_d      = !(strobe && !rd_lat_q);
      done_d      = last_recov;
   end

   // Engine state and registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         a0_lat_q    <= A0_DAT;
         rd_lat_q    <= 1'b0;
         dat_lat_q   <= 8'h00;
         req_ready_q <= 1'b1;
         cs_x_q      <= 1'b1;
         wr_x_q      <= 1'b1;
         a0_q        <= 1'b0;
         dat_o_q     <= 8'h00;
         dat_oe_q    <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         a0_lat_q    <= a0_lat_d;
         rd_lat_q    <= rd_lat_d;
         dat_lat_q   <= dat_lat_d;
         req_ready_q <= req_ready_d;
         cs_x_q      <= cs_x_d;
         wr_x_q      <= wr_x_d;
         a0_q        <= a0_d;
         dat_o_q     <= dat_o_d;
         dat_oe_q    <= dat_oe_d;
         done_q      <= done_d;
      end
   end

`ifdef HOST_BUS_RD_EN
   logic       rd_x_q, rd_x_d;
   logic [7:0] rd_data_q, rd_data_d;
   logic       rd_valid_q, rd_valid_d;

   // Read side: rd_x follows the strobe phase, data sampled on its last cycle.
   always_comb begin
      rd_x_d     = !(strobe && rd_lat_q);
      rd_data_d  = (strobe && tmr_tc && rd_lat_q) ? dat_i : rd_data_q;
      rd_valid_d = last_recov && rd_lat_q;
   end

   // Read-side registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_x_q     <= 1'b1;
         rd_data_q  <= 8'h00;
         rd_valid_q <= 1'b0;
      end else begin
         rd_x_q     <= rd_x_d;
         rd_data_q  <= rd_data_d;
         rd_valid_q <= rd_valid_d;
      end
   end

   assign rd_x     = rd_x_q;
   assign rd_data  = rd_data_q;
   assign rd_valid = rd_valid_q;
`else
   assign rd_x     = 1'b1;
   assign rd_data  = 8'h00;
   assign rd_valid = 1'b0;
`endif

   assign req_ready = req_ready_q;
   assign cs_x      = cs_x_q;
   assign wr_x      = wr_x_q;
   assign a0        = a0_q;
   assign dat_o     = dat_o_q;
   assign dat_oe    = dat_oe_q;
   assign done      = done_q;

endmodule

// File: tb/tb_host_bus_master.sv
// tb_host_bus_master: directed stimulus with a scoreboard. Requests push the
// expected access into a queue; a bus monitor on the default-timed instance
// rebuilds each access from the pins and checks it when done pulses. A second
// instance with stretched timing is checked against the edge formulas.
module tb_host_bus_master;

`ifdef HOST_BUS_RD_EN
   localparam bit RD_EN = 1'b1;
`else
   localparam bit RD_EN = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       req_valid_a = 1'b0, req_valid_b = 1'b0;
   logic       req_a0 = 1'b0, req_rd = 1'b0;
   logic [7:0] req_dat = 8'h00;

   logic       req_ready_a, done_a, rd_valid_a, cs_x_a, wr_x_a, rd_x_a, a0_a, dat_oe_a;
   logic [7:0] rd_data_a, dat_o_a, dat_i_a;
   logic       req_ready_b, done_b, rd_valid_b, cs_x_b, wr_x_b, rd_x_b, a0_b, dat_oe_b;
   logic [7:0] rd_data_b, dat_o_b, dat_i_b;

   always #5 clk = ~clk;

   // Bus slave model: drives 0xA5 only while rd_x is low.
   assign dat_i_a = rd_x_a ? 8'h00 : 8'hA5;
   assign dat_i_b = 8'h00;

   host_bus_master u_a (
      .clk(clk), .rst(rst), .req_valid(req_valid_a), .req_ready(req_ready_a),
      .req_a0(req_a0), .req_rd(req_rd), .req_dat(req_dat), .done(done_a),
      .rd_data(rd_data_a), .rd_valid(rd_valid_a), .cs_x(cs_x_a), .wr_x(wr_x_a),
      .rd_x(rd_x_a), .a0(a0_a), .dat_o(dat_o_a), .dat_oe(dat_oe_a), .dat_i(dat_i_a)
   );

   host_bus_master #(.SETUP_CYC(3), .PULSE_CYC(4), .HOLD_CYC(2), .RECOV_CYC(1)) u_b (
      .clk(clk), .rst(rst), .req_valid(req_valid_b), .req_ready(req_ready_b),
      .req_a0(req_a0), .req_rd(req_rd), .req_dat(req_dat), .done(done_b),
      .rd_data(rd_data_b), .rd_valid(rd_valid_b), .cs_x(cs_x_b), .wr_x(wr_x_b),
      .rd_x(rd_x_b), .a0(a0_b), .dat_o(dat_o_b), .dat_oe(dat_oe_b), .dat_i(dat_i_b)
   );

   typedef struct {
      logic       a0;
      logic       rd;
      logic [7:0] dat;   // write byte, or expected read byte
   } exp_t;

   exp_t exp_q[$];
   int   vec = 0;
   int   err = 0;
   int   done_cnt = 0;

   task automatic chk(input string name, input int act, input int exp);
      vec++;
      if (act != exp) begin
         err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // ---------------- monitor / scoreboard for u_a (defaults 1/2/1/2) -------
   localparam int A_CS_LO = 4;  // setup 1 + pulse 2 + hold 1
   localparam int A_PULSE = 2;

   bit         in_acc = 0, have_prev = 0, dat_bad = 0, a0_bad = 0, both_low = 0;
   int         cs_lo = 0, wr_lo = 0, rd_lo = 0, oe_lo = 0, hi_cnt = 0;
   logic       m_a0 = 1'b0;
   logic [7:0] m_dat = 8'h00;

   always @(negedge clk) begin
      if (rst) begin
         in_acc    = 0;
         have_prev = 0;
      end else begin
         if (!cs_x_a) begin
            if (!in_acc) begin
               if (have_prev) chk("cs_gap_ge2", int'(hi_cnt >= 2), 1);
               in_acc = 1; m_a0 = a0_a; m_dat = dat_o_a;
               cs_lo = 0; wr_lo = 0; rd_lo = 0; oe_lo = 0;
               dat_bad = 0; a0_bad = 0; both_low = 0;
            end
            cs_lo++;
            if (!wr_x_a) wr_lo++;
            if (!rd_x_a) rd_lo++;
            if (dat_oe_a) oe_lo++;
            if (!wr_x_a && !rd_x_a) both_low = 1;
            if (a0_a != m_a0) a0_bad = 1;
            if (dat_o_a != m_dat) dat_bad = 1;
         end else begin
            if (in_acc) begin
               in_acc = 0; have_prev = 1; hi_cnt = 0;
            end
            hi_cnt++;
         end
         if (done_a) begin
            done_cnt++;
            if (exp_q.size() == 0) begin
               chk("unexpected_done", 1, 0);
            end else begin
               exp_t e;
               e = exp_q.pop_front();
               chk("acc_a0", int'(m_a0), int'(e.a0));
               chk("acc_a0_stable", int'(a0_bad), 0);
               chk("acc_cs_lo_cycles", cs_lo, A_CS_LO);
               chk("acc_wr_lo_cycles", wr_lo, e.rd ? 0 : A_PULSE);
               chk("acc_rd_lo_cycles", rd_lo, e.rd ? A_PULSE : 0);
               chk("acc_oe_cycles", oe_lo, e.rd ? 0 : A_CS_LO);
               chk("acc_strobes_exclusive", int'(both_low), 0);
               chk("acc_rd_valid", int'(rd_valid_a), int'(e.rd));
               if (e.rd) begin
                  chk("acc_rd_data", int'(rd_data_a), int'(e.dat));
               end else begin
                  chk("acc_wr_data", int'(m_dat), int'(e.dat));
                  chk("acc_wr_data_stable", int'(dat_bad), 0);
               end
            end
         end else if (rd_valid_a) begin
            chk("rd_valid_without_done", 1, 0);
         end
      end
   end

   // ---------------- stimulus helpers -------------------------------------
   // Present a request at a negedge, wait for req_ready, return just after
   // the accepting posedge. req_valid is left high for back-to-back use.
   task automatic do_req(input int which, input logic a0v, input logic rdv,
                         input logic [7:0] datv, input bit push);
      int   n;
      logic rdy;
      exp_t e;
      @(negedge clk);
      req_a0 = a0v; req_rd = rdv; req_dat = datv;
      if (which == 0) req_valid_a = 1'b1; else req_valid_b = 1'b1;
      n = 0;
      rdy = (which == 0) ? req_ready_a : req_ready_b;
      while (!rdy && n < 100) begin
         @(negedge clk);
         n++;
         rdy = (which == 0) ? req_ready_a : req_ready_b;
      end
      if (!rdy) begin
         chk("req_ready_timeout", 0, 1);
         return;
      end
      if (push) begin
         e.a0  = a0v;
         e.rd  = rdv & RD_EN;
         e.dat = e.rd ? 8'hA5 : datv;
         exp_q.push_back(e);
      end
      @(posedge clk);
   endtask

   task automatic drain();
      int n = 0;
      while (exp_q.size() != 0 && n < 300) begin
         @(negedge clk);
         n++;
      end
      chk("scoreboard_drained", exp_q.size(), 0);
   endtask

   // Single write access; sample pins for 20 cycles after acceptance (k=0 is
   // the cycle right after the accepting edge) and compare against the edge
   // formulas: cs low k in [1,S+P+H], strobe low k in [S+1,S+P], done at
   // k=S+P+H+R, ready high from k=S+P+H+R+1.
   task automatic timing_check(input int which, input int s, input int p,
                               input int h, input int r, input logic [7:0] datv);
      logic [19:0] m_cs, m_st, m_rdy, m_dn, e_cs, e_st, e_rdy, e_dn;
      m_cs = '0; m_st = '0; m_rdy = '0; m_dn = '0;
      e_cs = '0; e_st = '0; e_rdy = '0; e_dn = '0;
      for (int k = 0; k < 20; k++) begin
         e_cs[k]  = (k >= 1) && (k <= s + p + h);
         e_st[k]  = (k >= s + 1) && (k <= s + p);
         e_dn[k]  = (k == s + p + h + r);
         e_rdy[k] = (k >= s + p + h + r + 1);
      end
      do_req(which, 1'b1, 1'b0, datv, which == 0);
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if (k == 0) begin
            req_valid_a = 1'b0;
            req_valid_b = 1'b0;
         end
         if (which == 0) begin
            m_cs[k] = !cs_x_a; m_st[k] = !(wr_x_a && rd_x_a);
            m_rdy[k] = req_ready_a; m_dn[k] = done_a;
         end else begin
            m_cs[k] = !cs_x_b; m_st[k] = !(wr_x_b && rd_x_b);
            m_rdy[k] = req_ready_b; m_dn[k] = done_b;
         end
      end
      chk("timing_cs_low_mask", int'(m_cs), int'(e_cs));
      chk("timing_strobe_mask", int'(m_st), int'(e_st));
      chk("timing_ready_mask", int'(m_rdy), int'(e_rdy));
      chk("timing_done_mask", int'(m_dn), int'(e_dn));
   endtask

   // ---------------- main sequence ----------------------------------------
   logic [7:0] seq_dat [13] = '{8'h40, 8'h01, 8'h02, 8'h03, 8'h04, 8'h48, 8'h05,
                                8'h06, 8'h42, 8'h22, 8'h33, 8'h44, 8'h40};
   logic       seq_a0  [13] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                                1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};

   initial begin
      int base;
      bit idle_bad;
      int n;

      // Reset values.
      repeat (3) @(negedge clk);
      chk("rst_cs_x", int'(cs_x_a), 1);
      chk("rst_wr_x", int'(wr_x_a), 1);
      chk("rst_rd_x", int'(rd_x_a), 1);
      chk("rst_a0", int'(a0_a), 0);
      chk("rst_dat_o", int'(dat_o_a), 0);
      chk("rst_dat_oe", int'(dat_oe_a), 0);
      chk("rst_req_ready", int'(req_ready_a), 1);
      chk("rst_done", int'(done_a), 0);
      chk("rst_rd_data", int'(rd_data_a), 0);
      chk("rst_rd_valid", int'(rd_valid_a), 0);
      rst = 1'b0;

      // Idle with no request: ready held, bus quiet.
      idle_bad = 0;
      repeat (8) begin
         @(negedge clk);
         if (!req_ready_a || !cs_x_a || !wr_x_a || done_a || dat_oe_a) idle_bad = 1;
      end
      chk("idle_quiet", int'(idle_bad), 0);

      // Command write 0x40 with default timing.
      timing_check(0, 1, 2, 1, 2, 8'h40);
      drain();

      // 13-access stream with req_valid held high.
      base = done_cnt;
      for (int i = 0; i < 13; i++)
         do_req(0, seq_a0[i], 1'b0, seq_dat[i], 1'b1);
      @(negedge clk);
      req_valid_a = 1'b0;
      drain();
      repeat (3) @(negedge clk);
      chk("stream_done_count", done_cnt - base, 13);

      // Stretched timing 3/4/2/1 on the second instance.
      timing_check(1, 3, 4, 2, 1, 8'h5C);

      // Read (a write when reads are compiled out).
      do_req(0, 1'b0, 1'b1, 8'h5A, 1'b1);
      @(negedge clk);
      req_valid_a = 1'b0;
      drain();

      // Reset during the strobe aborts the access.
      base = done_cnt;
      do_req(0, 1'b1, 1'b0, 8'h77, 1'b0);
      @(negedge clk);
      req_valid_a = 1'b0;
      n = 0;
      while (wr_x_a && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("abort_reached_strobe", int'(wr_x_a), 0);
      rst = 1'b1;
      @(negedge clk);
      chk("abort_cs_x", int'(cs_x_a), 1);
      chk("abort_wr_x", int'(wr_x_a), 1);
      chk("abort_dat_oe", int'(dat_oe_a), 0);
      chk("abort_req_ready", int'(req_ready_a), 1);
      rst = 1'b0;
      repeat (10) @(negedge clk);
      chk("abort_no_done", done_cnt - base, 0);

      // Next request after the abort completes normally.
      do_req(0, 1'b0, 1'b0, 8'h3C, 1'b1);
      @(negedge clk);
      req_valid_a = 1'b0;
      drain();
      chk("post_abort_done", done_cnt - base, 1);

      $display("== %0d vectors applied, %0d miscompares ==", vec, err);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, vectors %0d", vec);
      $fatal(1);
   end

endmodule
